// File: rtl/fifo_flush_sched_if.sv
// fifo_flush_sched bus bundle
// requesters, FIFO side and consumer side
interface fifo_flush_sched_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [4*NUM_REQ-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic                 flush_req_i;
  logic                 fifo_wr_valid_o;
  logic [3:0]           fifo_wr_data_o;
  logic                 fifo_full_i;
  logic                 fifo_flush_o;
  logic                 fifo_data_avail_i;
  logic                 fifo_rd_valid_o;
  logic [31:0]          fifo_rd_data_i;
  logic                 out_valid_o;
  logic [31:0]          out_data_o;
  logic                 out_ready_i;
  logic [5:0]           level_o;
  logic                 busy_o;
  logic                 err_o;

  modport slave (
    input  req_valid_i, req_data_i,
    input  flush_req_i, fifo_full_i,
    input  fifo_data_avail_i,
    input  fifo_rd_data_i, out_ready_i,
    output req_ready_o,
    output fifo_wr_valid_o, fifo_wr_data_o,
    output fifo_flush_o, fifo_rd_valid_o,
    output out_valid_o, out_data_o,
    output level_o, busy_o, err_o
  );

  modport master (
    output req_valid_i, req_data_i,
    output flush_req_i, fifo_full_i,
    output fifo_data_avail_i,
    output fifo_rd_data_i, out_ready_i,
    input  req_ready_o,
    input  fifo_wr_valid_o, fifo_wr_data_o,
    input  fifo_flush_o, fifo_rd_valid_o,
    input  out_valid_o, out_data_o,
    input  level_o, busy_o, err_o
  );
endinterface

// File: rtl/fifo_flush_sched.sv
// fifo_flush_sched: nibble arbiter and
// flush scheduler for the 32-bit flush FIFO
module fifo_flush_sched #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 32,
  parameter int THRESH  = 8,
  parameter int IDLE_TO = 16
) (
  input logic                clk,
  input logic                reset,
  fifo_flush_sched_if.slave  bus
);

  localparam int PW =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(IDLE_TO + 1);

  localparam logic [5:0] DEPTH_L  = 6'(DEPTH);
  localparam logic [5:0] THRESH_L = 6'(THRESH);
  localparam logic [CW-1:0] TO_L  = CW'(IDLE_TO);
  localparam logic [CW-1:0] TO_M1 =
    CW'(IDLE_TO - 1);
  localparam logic [PW-1:0] LAST  =
    PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [PW-1:0] ptr;
  logic [5:0]    level;
  logic [CW-1:0] idle_cnt;
  logic [CW-1:0] wait_cnt;
  logic          pend;
  logic          err;
  logic [31:0]   out_q;
  logic          out_v;

  logic               trig;
  logic               gnt_ok;
  logic               wr;
  logic               cap;
  logic               tmo;
  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      gnt_idx;
  logic [3:0]         gnt_data;
  logic [5:0]         sub;

  // flush trigger; it wins over writes
  assign trig = (level != 6'd0) &&
                (pend || level >= THRESH_L ||
                 idle_cnt == TO_L);

  assign gnt_ok = (state == S_IDLE) && !trig &&
                  !bus.fifo_full_i &&
                  (level < DEPTH_L);

  // round-robin search from ptr upward
  always_comb begin
    int   idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    gnt      = '0;
    gnt_idx  = '0;
    gnt_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && bus.req_valid_i[idx]) begin
        found   = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    if (gnt_ok && found) begin
      gnt[gnt_idx] = 1'b1;
      gnt_data =
        bus.req_data_i[4*gnt_idx +: 4];
    end
  end

  assign wr  = |gnt;
  assign cap = (state == S_FLUSH) &&
               bus.fifo_data_avail_i;
  assign tmo = (state == S_FLUSH) &&
               !bus.fifo_data_avail_i &&
               (wait_cnt == TO_M1);
  assign sub = (level > 6'd8) ? 6'd8 : level;

  // next-state logic for the flush sequence
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (trig) state_n = S_FLUSH;
      S_FLUSH: begin
        if (cap)      state_n = S_HOLD;
        else if (tmo) state_n = S_DRAIN;
      end
      S_HOLD:
        if (bus.out_ready_i) state_n = S_DRAIN;
      S_DRAIN: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // state, pointer, level and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ptr      <= '0;
      level    <= '0;
      idle_cnt <= '0;
      wait_cnt <= '0;
      pend     <= 1'b0;
      err      <= 1'b0;
      out_q    <= '0;
      out_v    <= 1'b0;
    end else begin
      state <= state_n;
      out_v <= (state_n == S_HOLD);

      if (wr)
        ptr <= (gnt_idx == LAST) ?
               '0 : gnt_idx + 1'b1;

      if (wr && level != DEPTH_L)
        level <= level + 6'd1;
      else if (cap)
        level <= level - sub;

      if (wr || level == 6'd0)
        idle_cnt <= '0;
      else if (idle_cnt != TO_L)
        idle_cnt <= idle_cnt + 1'b1;

      if (state != S_FLUSH)
        wait_cnt <= '0;
      else if (!cap)
        wait_cnt <= wait_cnt + 1'b1;

      // a new request survives the empty clear
      if (state == S_IDLE && trig)
        pend <= 1'b0;
      else if (bus.flush_req_i)
        pend <= 1'b1;
      else if (state == S_IDLE &&
               level == 6'd0)
        pend <= 1'b0;

      if (tmo) err <= 1'b1;
      if (cap) out_q <= bus.fifo_rd_data_i;
    end
  end

  assign bus.req_ready_o     = gnt;
  assign bus.fifo_wr_valid_o = wr;
  assign bus.fifo_wr_data_o  = gnt_data;
  assign bus.fifo_flush_o    =
    (state == S_FLUSH);
  assign bus.fifo_rd_valid_o = cap;
  assign bus.out_valid_o     = out_v;
  assign bus.out_data_o      = out_q;
  assign bus.level_o         = level;
  assign bus.busy_o          = (state != S_IDLE);
  assign bus.err_o           = err;

endmodule

// File: tb/tb_fifo_flush_sched.sv
// tb_fifo_flush_sched: random stimulus against
// a queue-based model of the flush scheduler
module tb_fifo_flush_sched;

  localparam int N    = 4;
  localparam int DEP  = 32;
  localparam int THR  = 8;
  localparam int TO   = 16;
  localparam int NSEG = 7;

  localparam int P_IDLE  = 0;
  localparam int P_FLUSH = 1;
  localparam int P_HOLD  = 2;
  localparam int P_DRAIN = 3;

  logic clk = 1'b0;
  logic reset;

  fifo_flush_sched_if #(.NUM_REQ(N)) bus();

  fifo_flush_sched #(
    .NUM_REQ(N), .DEPTH(DEP),
    .THRESH(THR), .IDLE_TO(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h exp=%h",
               tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(
    input logic [3:0] q[$]);
    logic [31:0] w;
    w = 32'hCCCC_CCCC;
    for (int i = 0; i < 8 && i < q.size(); i++)
      w[4*i +: 4] = q[i];
    return w;
  endfunction

  // model state
  int          m_ph, m_ptr, m_lvl;
  int          m_idle, m_wait;
  bit          m_pend, m_err;
  logic [31:0] m_word;
  logic [3:0]  mq[$];

  // environment FIFO
  logic [3:0]  fq[$];
  int          fl_cnt, lat;
  bit          hang;

  int v_pct[NSEG]   = '{5, 100, 20, 30, 60, 80, 50};
  int full_pct[NSEG]= '{0,   0,  0,  0,  0, 50, 10};
  int fr_pct[NSEG]  = '{0,   0, 10,  2,  5,  5, 10};
  int hang_pct[NSEG]= '{0,   0,  0,100,  0,  0, 20};
  int rdy_pct[NSEG] = '{100,100, 70, 90, 10, 50, 50};
  int rst_pct[NSEG] = '{0,   0,  0,  0,  0,  0, 25};

  task automatic model_reset();
    m_ph = P_IDLE; m_ptr = 0; m_lvl = 0;
    m_idle = 0; m_wait = 0;
    m_pend = 0; m_err = 0;
    m_word = '0;
    mq.delete();
  endtask

  bit          trig, wr, cap;
  int          gidx, n;
  logic [3:0]  nib;
  logic [N-1:0] e_rdy;

  initial begin
    reset = 1'b1;
    bus.req_valid_i = '0;
    bus.req_data_i = '0;
    bus.flush_req_i = 1'b0;
    bus.fifo_full_i = 1'b0;
    bus.fifo_data_avail_i = 1'b0;
    bus.fifo_rd_data_i = '0;
    bus.out_ready_i = 1'b0;
    model_reset();
    fq.delete(); fl_cnt = 0; lat = 0; hang = 0;
    repeat (2) @(posedge clk);

    for (int s = 0; s < NSEG; s++) begin
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        reset = (m_ph == P_FLUSH) &&
          ($urandom_range(0, 99) < rst_pct[s]);
        for (int i = 0; i < N; i++)
          bus.req_valid_i[i] =
            ($urandom_range(0, 99) < v_pct[s]);
        bus.req_data_i = 16'($urandom);
        bus.flush_req_i =
          ($urandom_range(0, 99) < fr_pct[s]);
        bus.fifo_full_i =
          ($urandom_range(0, 99) < full_pct[s]);
        bus.out_ready_i =
          ($urandom_range(0, 99) < rdy_pct[s]);
        if (bus.fifo_flush_o && fl_cnt == 0) begin
          lat  = $urandom_range(0, 4);
          hang = ($urandom_range(0, 99) <
                  hang_pct[s]);
        end
        bus.fifo_data_avail_i = bus.fifo_flush_o &&
          fl_cnt >= lat && !hang;
        bus.fifo_rd_data_i = pack(fq);
        #1;

        // expected behaviour this cycle
        trig = m_lvl > 0 && (m_pend ||
          m_lvl >= THR || m_idle == TO);
        gidx = -1;
        if (m_ph == P_IDLE && !trig &&
            !bus.fifo_full_i && m_lvl < DEP)
          for (int k = 0; k < N; k++)
            if (gidx < 0 &&
                bus.req_valid_i[(m_ptr+k)%N])
              gidx = (m_ptr + k) % N;
        wr  = (gidx >= 0);
        cap = (m_ph == P_FLUSH) &&
              bus.fifo_data_avail_i;
        e_rdy = '0;
        nib   = '0;
        if (wr) begin
          e_rdy[gidx] = 1'b1;
          nib = bus.req_data_i[4*gidx +: 4];
        end

        chk("req_ready", bus.req_ready_o, e_rdy);
        chk("wr_valid", bus.fifo_wr_valid_o, wr);
        chk("wr_data", bus.fifo_wr_data_o, nib);
        chk("flush", bus.fifo_flush_o,
            m_ph == P_FLUSH);
        chk("rd_valid", bus.fifo_rd_valid_o, cap);
        chk("out_valid", bus.out_valid_o,
            m_ph == P_HOLD);
        chk("out_data", bus.out_data_o, m_word);
        chk("level", bus.level_o, m_lvl);
        chk("busy", bus.busy_o, m_ph != P_IDLE);
        chk("err", bus.err_o, m_err);

        // environment FIFO follows the DUT
        if (reset) begin
          fq.delete(); fl_cnt = 0;
        end else begin
          if (bus.fifo_rd_valid_o) begin
            n = (fq.size() < 8) ? fq.size() : 8;
            repeat (n) void'(fq.pop_front());
          end
          if (bus.fifo_wr_valid_o)
            fq.push_back(bus.fifo_wr_data_o);
          fl_cnt = bus.fifo_flush_o ?
                   fl_cnt + 1 : 0;
        end

        // model advances one clock
        if (reset) begin
          model_reset();
        end else begin
          if (m_ph == P_IDLE && trig)
            m_pend = 0;
          else if (bus.flush_req_i)
            m_pend = 1;
          else if (m_ph == P_IDLE && m_lvl == 0)
            m_pend = 0;
          if (wr || m_lvl == 0) m_idle = 0;
          else if (m_idle < TO) m_idle++;
          if (wr) begin
            mq.push_back(nib);
            m_lvl = (m_lvl < DEP) ? m_lvl + 1 : DEP;
            m_ptr = (gidx + 1) % N;
          end
          case (m_ph)
            P_IDLE: if (trig) begin
              m_ph = P_FLUSH; m_wait = 0;
            end
            P_FLUSH: begin
              if (cap) begin
                m_word = pack(mq);
                n = (m_lvl < 8) ? m_lvl : 8;
                m_lvl -= n;
                repeat (n) void'(mq.pop_front());
                m_ph = P_HOLD;
              end else begin
                m_wait++;
                if (m_wait == TO) begin
                  m_err = 1; m_ph = P_DRAIN;
                end
              end
            end
            P_HOLD:
              if (bus.out_ready_i) m_ph = P_DRAIN;
            default: m_ph = P_IDLE;
          endcase
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_flush_sched.md
Name: fifo_flush_sched

Overview:
- Controller for the nibble-write / 32-bit-flush FIFO.
- Round-robin arbitrates NUM_REQ nibble producers onto the single FIFO write port.
- Tracks FIFO occupancy and schedules flushes: explicit request, fill threshold, or idle timeout.
- Sequences the flush/read handshake and returns each flushed 32-bit word to one downstream consumer via valid/ready.

Parameters:
- NUM_REQ, 4, number of nibble requesters (2..8)
- DEPTH, 32, FIFO capacity in nibbles
- THRESH, 8, occupancy at or above which a flush is auto-scheduled (1..DEPTH)
- IDLE_TO, 16, cycles without a write before a non-empty FIFO is auto-flushed; also the avail-wait timeout

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid_i  in  NUM_REQ  per-requester nibble valid
- req_data_i  in  4*NUM_REQ  nibble of requester i at [4i+:4]
- req_ready_o  out  NUM_REQ  one-hot grant; transfer when valid&ready
- flush_req_i  in  1  software flush request, pulse or level
- fifo_wr_valid_o  out  1  FIFO write strobe
- fifo_wr_data_o  out  4  FIFO write nibble
- fifo_full_i  in  1  FIFO full
- fifo_flush_o  out  1  FIFO flush request
- fifo_data_avail_i  in  1  FIFO flushed word valid
- fifo_rd_valid_o  out  1  FIFO read acknowledge
- fifo_rd_data_i  in  32  FIFO flushed word, 0xC-padded
- out_valid_o  out  1  flushed word valid to consumer
- out_data_o  out  32  flushed word
- out_ready_i  in  1  consumer accept
- level_o  out  6  tracked occupancy, 0..DEPTH
- busy_o  out  1  FSM not in IDLE
- err_o  out  1  sticky: avail timeout seen; cleared only by reset

Behaviour:
- Reset (sync, reset=1 at posedge) clears all registers. All outputs are 0 after reset: state IDLE, RR pointer 0, level 0, counters 0, pending 0, err 0.
- Arbitration, combinational grant:
  - Grant is allowed only when state==IDLE, !fifo_full_i and level<DEPTH.
  - Grant goes to the first requester with valid set, searching from RR pointer upward, modulo NUM_REQ.
  - req_ready_o is one-hot or zero. fifo_wr_valid_o = |req_ready_o; fifo_wr_data_o = the granted nibble (0 when no grant).
  - On a transfer, RR pointer <= granted index+1 mod NUM_REQ; otherwise the pointer holds.
- Level: +1 per write. Reduced by min(8, level) when a word is captured. Write and capture are never in the same cycle, because writes happen only in IDLE. Saturates at DEPTH; level never wraps.
- Idle counter: reset to 0 on a write or when level==0; otherwise increments, saturating at IDLE_TO.
- pending: set by flush_req_i=1 in any state; cleared on entry to FLUSH.
- Trigger, evaluated in IDLE: level>0 and (pending or level>=THRESH or idle counter==IDLE_TO).
- pending with level==0 is cleared in IDLE without flushing.
- FSM:
  - IDLE: on trigger -> FLUSH next cycle. No grant in the trigger cycle: trigger has priority over writes.
  - FLUSH: fifo_flush_o=1. Wait counter starts at 0.
    - If fifo_data_avail_i=1: capture fifo_rd_data_i into the out register, fifo_rd_valid_o=1 for this cycle, update level -> HOLD.
    - Otherwise wait counter +1. When it reaches IDLE_TO -> set err_o, go to DRAIN with no capture and no level change.
  - HOLD: fifo_flush_o=0, out_valid_o=1, out_data_o stable. On out_ready_i=1 -> DRAIN.
  - DRAIN: one cycle, all FIFO strobes 0 -> IDLE. Guarantees at least one cycle of flush deassertion between flushes.
- out_valid_o is registered and asserted only in HOLD. out_data_o holds the last captured word; 0 after reset.
- busy_o = (state!=IDLE).
- Reset asserted mid-flush: next cycle is IDLE with all outputs 0. The FIFO is reset by the same reset line, so level 0 is consistent.

Test Plan:
- Req0 alone writes 1,2,3 (THRESH=8) then idles 16 cycles -> idle trigger; fifo_flush_o rises; model avail returns 0xCCCCC321 -> out_valid_o with 0xCCCCC321, fifo_rd_valid_o for 1 cycle, level_o 3->0.
- All 4 requesters valid continuously -> grants cycle 0,1,2,3,0,1,2,3; after 8 writes level_o=8, the next cycle triggers FLUSH, no 9th grant; captured word = nibbles in grant order.
- flush_req_i pulse at level 0 -> no fifo_flush_o, pending cleared. Pulse at level 5 -> flush occurs, level_o 5->0.
- fifo_data_avail_i held 0 during FLUSH -> after 16 cycles err_o=1 (sticky), DRAIN, back in IDLE with level unchanged.
- out_ready_i held 0 for 10 cycles in HOLD -> out_valid_o and out_data_o stable; no grants, busy_o=1; on ready -> DRAIN then IDLE, grants resume.
- fifo_full_i=1 with requests pending -> req_ready_o=0. Reset pulse in the middle of FLUSH -> all outputs 0 the next cycle, state IDLE.
